// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared constants and default-divisor helper for the frequency divider
package freq_pkg;

    localparam int CH_FAST = 0;
    localparam int CH_SLOW = 1;
    localparam int DIV_MIN = 2;

    // Returns 0 for a zero target frequency so the caller's range check rejects it.
    function automatic longint unsigned div_default(input longint unsigned clk_hz,
                                                    input longint unsigned f_hz);
        return (f_hz == 64'd0) ? 64'd0 : clk_hz / f_hz;
    endfunction

endpackage

// File: rtl/divisor_frecuencia_div_canal.sv
// rtl/divisor_frecuencia_div_canal.sv - one divider channel: counter, active/shadow divisor, tick, square wave
module div_canal
    import freq_pkg::*;
#(
    parameter int               CNT_W     = 32,
    parameter logic [CNT_W-1:0] RESET_DIV = CNT_W'(DIV_MIN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] val,
    output logic             busy,
    output logic             done,
    output logic             tick,
    output logic             sq
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_act;
    logic [CNT_W-1:0] shadow;
    logic             pending;
    logic             tick_r;
    logic             sq_r;
    logic             done_r;

    logic             wrap;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] n_next;
    logic [CNT_W-1:0] val_clamped;

    always_comb begin
        wrap        = en && (cnt == n_act - CNT_W'(1));
        cnt_next    = wrap ? '0 : cnt + CNT_W'(1);
        n_next      = (wrap && pending) ? shadow : n_act;
        val_clamped = (val < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : val;
    end

    // sq is computed from the post-edge count and divisor so a new period is
    // already shaped by the new divisor, with no glitch at the boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            n_act   <= RESET_DIV;
            shadow  <= '0;
            pending <= 1'b0;
            tick_r  <= 1'b0;
            sq_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            tick_r <= 1'b0;
            if (en) begin
                cnt    <= cnt_next;
                tick_r <= wrap;
                sq_r   <= (cnt_next < (n_next >> 1));
                if (wrap && pending) begin
                    n_act   <= shadow;
                    pending <= 1'b0;
                    done_r  <= 1'b1;
                end
            end
            // A load on the wrap edge re-arms pending after the apply above.
            if (load) begin
                shadow  <= val_clamped;
                pending <= 1'b1;
            end
        end
    end

    assign busy = pending;
    assign done = done_r;
    assign tick = tick_r;
    assign sq   = sq_r;

endmodule

// File: rtl/divisor_frecuencia.sv
// rtl/divisor_frecuencia.sv - fast/slow time-base generator with reloadable divisors
module divisor_frecuencia
    import freq_pkg::*;
#(
    parameter longint unsigned CLK_HZ    = 100_000_000,
    parameter longint unsigned F_FAST_HZ = 10_000,
    parameter longint unsigned F_SLOW_HZ = 1,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_load,
    input  logic             div_sel,
    input  logic [CNT_W-1:0] div_val,
    output logic [1:0]       div_busy,
    output logic [1:0]       div_done,
    output logic             tick_fast,
    output logic             tick_slow,
    output logic             sq_fast,
    output logic             sq_slow
);

    localparam longint unsigned N_FAST = div_default(CLK_HZ, F_FAST_HZ);
    localparam longint unsigned N_SLOW = div_default(CLK_HZ, F_SLOW_HZ);
    localparam longint unsigned N_LIM  = 64'd1 << CNT_W;

    if (N_FAST < 64'(DIV_MIN) || N_FAST >= N_LIM) begin : g_bad_fast
        $error("divisor_frecuencia: fast default divisor out of range");
    end
    if (N_SLOW < 64'(DIV_MIN) || N_SLOW >= N_LIM) begin : g_bad_slow
        $error("divisor_frecuencia: slow default divisor out of range");
    end

    logic load_fast;
    logic load_slow;

    assign load_fast = div_load && !div_sel;
    assign load_slow = div_load && div_sel;

    div_canal #(
        .CNT_W    (CNT_W),
        .RESET_DIV(CNT_W'(N_FAST))
    ) u_fast (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .load(load_fast),
        .val (div_val),
        .busy(div_busy[CH_FAST]),
        .done(div_done[CH_FAST]),
        .tick(tick_fast),
        .sq  (sq_fast)
    );

    div_canal #(
        .CNT_W    (CNT_W),
        .RESET_DIV(CNT_W'(N_SLOW))
    ) u_slow (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .load(load_slow),
        .val (div_val),
        .busy(div_busy[CH_SLOW]),
        .done(div_done[CH_SLOW]),
        .tick(tick_slow),
        .sq  (sq_slow)
    );

endmodule

// File: tb/tb_divisor_frecuencia.sv
// tb/tb_divisor_frecuencia.sv - self-checking bench for divisor_frecuencia
module tb_divisor_frecuencia;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             div_load;
    logic             div_sel;
    logic [CNT_W-1:0] div_val;
    logic [1:0]       div_busy;
    logic [1:0]       div_done;
    logic             tick_fast;
    logic             tick_slow;
    logic             sq_fast;
    logic             sq_slow;

    divisor_frecuencia #(
        .CLK_HZ   (100),
        .F_FAST_HZ(10),
        .F_SLOW_HZ(1),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_load (div_load),
        .div_sel  (div_sel),
        .div_val  (div_val),
        .div_busy (div_busy),
        .div_done (div_done),
        .tick_fast(tick_fast),
        .tick_slow(tick_slow),
        .sq_fast  (sq_fast),
        .sq_slow  (sq_slow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        ld;
        logic        sel;
        logic [31:0] val;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[17];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc_n = 0;
    int ts_cnt = 0;
    int tq[$];
    int dq[$];

    // Reference model state, indexed by channel (0 = fast, 1 = slow)
    int unsigned m_n[2];
    int unsigned m_cnt[2];
    int unsigned m_sh[2];
    bit          m_pend[2];
    bit          m_tick[2];
    bit          m_sq[2];
    bit          m_done[2];

    function automatic vec_t mk(input logic e, input logic l, input logic s,
                                input logic [31:0] v, input logic [7:0] x);
        vec_t r;
        r.en = e; r.ld = l; r.sel = s; r.val = v; r.exp = x;
        return r;
    endfunction

    function automatic logic [7:0] dut_vec();
        return {div_busy, div_done, tick_fast, tick_slow, sq_fast, sq_slow};
    endfunction

    function automatic logic [7:0] model_vec();
        return {m_pend[1], m_pend[0], m_done[1], m_done[0],
                m_tick[0], m_tick[1], m_sq[0], m_sq[1]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    task automatic model_reset();
        m_n[0] = 10; m_n[1] = 100;
        for (int ch = 0; ch < 2; ch++) begin
            m_cnt[ch] = 0; m_sh[ch] = 0; m_pend[ch] = 0;
            m_tick[ch] = 0; m_sq[ch] = 0; m_done[ch] = 0;
        end
    endtask

    task automatic model_step(input bit e, input bit l, input bit s, input int unsigned v);
        for (int ch = 0; ch < 2; ch++) begin
            m_done[ch] = 0;
            if (e) begin
                m_tick[ch] = (m_cnt[ch] == m_n[ch] - 1);
                if (m_tick[ch]) begin
                    m_cnt[ch] = 0;
                    if (m_pend[ch]) begin
                        m_n[ch] = m_sh[ch]; m_pend[ch] = 0; m_done[ch] = 1;
                    end
                end else begin
                    m_cnt[ch]++;
                end
                m_sq[ch] = (m_cnt[ch] < m_n[ch] / 2);
            end else begin
                m_tick[ch] = 0;
            end
            if (l && (int'(s) == ch)) begin
                m_sh[ch] = (v < 2) ? 2 : v;
                m_pend[ch] = 1;
            end
        end
    endtask

    task automatic cyc(input bit e, input bit l, input bit s, input int unsigned v);
        en = e; div_load = l; div_sel = s; div_val = v;
        @(posedge clk);
        model_step(e, l, s, v);
        #1;
        cyc_n++;
        check("model", 32'(dut_vec()), 32'(model_vec()));
        if (tick_fast) tq.push_back(cyc_n);
        if (tick_slow) ts_cnt++;
        if (div_done[0]) dq.push_back(cyc_n);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        en = 1'b0; div_load = 1'b0; div_sel = 1'b0; div_val = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc_n = 0; ts_cnt = 0;
        tq.delete(); dq.delete();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; div_load = 1'b0; div_sel = 1'b0; div_val = '0;

        // Rows: inputs before edge k, outputs after edge k.
        // exp = {busy[1:0], done[1:0], tick_fast, tick_slow, sq_fast, sq_slow}
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b00_00_0_0_1_1);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b00_00_0_0_1_1);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b00_00_0_0_1_1);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 32'd7, 8'b01_00_0_0_1_1);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b01_00_0_0_0_1);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b01_00_0_0_0_1);
        tbl[6]  = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b01_00_0_0_0_1);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b01_00_0_0_0_1);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b01_00_0_0_0_1);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b00_01_1_0_1_1);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b00_00_0_0_1_1);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b00_00_0_0_1_1);
        tbl[12] = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b00_00_0_0_0_1);
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b00_00_0_0_0_1);
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b00_00_0_0_0_1);
        tbl[15] = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b00_00_0_0_0_1);
        tbl[16] = mk(1'b1, 1'b0, 1'b0, 32'd0, 8'b00_00_1_0_1_1);

        do_reset();
        check("reset_outputs", 32'(dut_vec()), 32'h0);

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].en, tbl[i].ld, tbl[i].sel, tbl[i].val);
            check($sformatf("table_row%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
        end

        // 300 free-running cycles at the reset divisors
        do_reset();
        run(300);
        check("fast_tick_count", tq.size(), 30);
        check("slow_tick_count", ts_cnt, 3);
        check("first_fast_tick", (tq.size() > 0) ? tq[0] : -1, 10);

        // Two loads before the wrap: last write wins, one done pulse
        do_reset();
        run(2);
        cyc(1'b1, 1'b1, 1'b0, 4);
        run(2);
        cyc(1'b1, 1'b1, 1'b0, 6);
        run(24);
        check("double_load_done_count", dq.size(), 1);
        check("double_load_done_at", (dq.size() > 0) ? dq[0] : -1, 10);
        check("double_load_period", (tq.size() > 1) ? tq[1] : -1, 16);

        // Clamp of div_val=0 to period 2
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 0);
        run(29);
        check("clamp_gap1", (tq.size() > 2) ? tq[1] - tq[0] : -1, 2);
        check("clamp_gap2", (tq.size() > 2) ? tq[2] - tq[1] : -1, 2);

        // Load on the exact wrap edge applies at the following wrap
        do_reset();
        run(9);
        cyc(1'b1, 1'b1, 1'b0, 5);
        check("wrap_load_no_done", 32'(div_done), 32'h0);
        check("wrap_load_busy", 32'(div_busy), 32'h1);
        run(20);
        check("wrap_load_done_count", dq.size(), 1);
        check("wrap_load_done_at", (dq.size() > 0) ? dq[0] : -1, 20);
        check("wrap_load_next_tick", (tq.size() > 2) ? tq[2] : -1, 25);

        // en low for 25 cycles mid-period
        do_reset();
        run(4);
        for (int i = 0; i < 25; i++) cyc(1'b0, 1'b0, 1'b0, 0);
        check("freeze_no_ticks", tq.size(), 0);
        run(6);
        check("freeze_resume_tick", (tq.size() > 0) ? tq[0] : -1, 35);

        // Asynchronous reset mid-period after a load
        do_reset();
        run(3);
        cyc(1'b1, 1'b1, 1'b0, 7);
        run(2);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'(dut_vec()), 32'h0);
        #1 rst = 1'b0;
        model_reset();
        cyc_n = 0; tq.delete(); dq.delete();
        run(20);
        check("async_reset_no_done", dq.size(), 0);
        check("async_reset_tick1", (tq.size() > 0) ? tq[0] : -1, 10);
        check("async_reset_tick2", (tq.size() > 1) ? tq[1] : -1, 20);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit          e;
            bit          l;
            bit          s;
            int unsigned v;
            e = ($urandom_range(9) != 0);
            l = ($urandom_range(15) == 0);
            s = 1'($urandom_range(1));
            v = $urandom_range(20);
            cyc(e, l, s, v);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/divisor_frecuencia.md
Name: divisor_frecuencia

Overview:
- Produces the motor controller's time bases from the 100 MHz system clock.
- Two channels:
  - fast: 10 kHz, the PWM carrier rate.
  - slow: 1 Hz, supervision/blink rate.
- Each channel gives a one-cycle tick enable and a square wave.
- Divisors are runtime-reloadable through a load/done handshake and take effect glitch-free at the next period boundary.
- Sits directly downstream of the system clock source; feeds the PWM generator and the slow housekeeping logic.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- F_FAST_HZ, 10_000, fast channel reset frequency in Hz.
- F_SLOW_HZ, 1, slow channel reset frequency in Hz.
- CNT_W, 32, counter and divisor width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global count enable; low freezes both channels.
- div_load  in  1  one-cycle request to load a new divisor.
- div_sel  in  1  channel target of div_load: 0 = fast, 1 = slow.
- div_val  in  CNT_W  requested divisor N, in clk cycles per period.
- div_busy  out  2  per channel [0]=fast, [1]=slow; a loaded divisor is pending.
- div_done  out  2  per channel; one-cycle pulse when a pending divisor is applied.
- tick_fast  out  1  one-cycle pulse, every N_fast enabled cycles.
- tick_slow  out  1  one-cycle pulse, every N_slow enabled cycles.
- sq_fast  out  1  square wave at the fast rate.
- sq_slow  out  1  square wave at the slow rate.

Behaviour:
- Reset values:
  - all outputs 0; counters 0.
  - active divisors N_fast = CLK_HZ/F_FAST_HZ and N_slow = CLK_HZ/F_SLOW_HZ.
  - shadow registers cleared; pending flags 0.
- Counter, per channel:
  - cnt runs 0..N-1 while en=1, wraps to 0 after N-1.
  - en=0 holds cnt, tick forced 0, sq held.
- Tick:
  - registered; high for exactly the cycle after cnt == N-1.
  - first tick_fast appears N enabled cycles after the first enabled edge following reset release.
- Square wave:
  - registered; sq = 1 while cnt < N/2 (floor), else 0.
  - for odd N the low phase is one cycle longer.
- Divisor clamp: div_val < 2 is clamped to 2; a clamped load is still accepted.
- Load handshake:
  - div_load=1 at an edge captures the clamped div_val into that channel's shadow and sets pending.
  - div_busy[ch] goes high the next cycle.
  - A load while pending overwrites the shadow: last write wins, with no extra done pulse.
- Apply:
  - On the edge where cnt wraps (cnt == N-1 and en=1) with pending=1: active N := shadow, pending cleared, div_done[ch] pulses for one cycle.
  - The new period starts immediately at cnt=0.
  - The old period always completes; there are no runt ticks or sq glitches.
- Simultaneous load and wrap on the same edge:
  - The wrap uses the old pending state.
  - The new value becomes pending and applies at the following wrap.
- en=0 with a pending load: stays pending until a wrap occurs with en=1.
- Reset mid-period: asynchronous clear of the counter, sq, tick and pending; divisors return to their parameter defaults.
- Arithmetic:
  - Unsigned CNT_W compare.
  - Parameter defaults computed at elaboration; elaboration error if a default is < 2 or ≥ 2^CNT_W.

Decomposition:
- Package freq_pkg holds:
  - CH_FAST=0, CH_SLOW=1.
  - DIV_MIN=2.
  - the default-divisor function div_default(clk_hz, f_hz).
- One sub-module div_canal: one channel containing counter, active and shadow divisor, pending flag, tick, sq and done.
  - Parameter RESET_DIV.
  - Instantiated twice, load gated by div_sel.
- Top level is only the decode and the instantiations.

Test Plan:
- All tests run with CLK_HZ=100, F_FAST_HZ=10, F_SLOW_HZ=1 (N_fast=10, N_slow=100).
- Reset then en=1 for 300 cycles:
  - tick_fast at cycles 10, 20, 30...; tick_slow at 100, 200, 300.
  - sq_fast high 5 cycles, low 5 cycles.
- div_load with sel=0, val=7 at cnt=3:
  - busy[0]=1 next cycle.
  - The current 10-cycle period completes; done[0] pulses at the wrap.
  - Following ticks are 7 apart; sq_fast high 3, low 4.
- Two loads, sel=0 (val 4 then val 6), before the wrap:
  - exactly one done[0] pulse; period becomes 6.
- div_load with val=0 → clamped: period 2, tick every other cycle, sq toggles every cycle.
- Load asserted on the exact wrap edge:
  - not applied at that wrap; applied at the next wrap, 10 cycles later, with a done pulse.
- Edge cases:
  - en=0 for 25 cycles mid-period: counter and sq frozen, no ticks; the period resumes with the correct remaining count.
  - rst pulsed asynchronously mid-period after a load: outputs 0 immediately, pending dropped, N_fast back to 10.
